// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, SX bit positions, ALU opcodes, sequencer
// state encoding and opcode classes.
package cpu_pkg;

    localparam int WORD_W = 20;
    localparam int FLAG_W = 13;
    localparam int NREGS  = 16;
    localparam int ADDR_W = $clog2(NREGS);
    localparam int OP_W   = 14;

    localparam int SX_ZE = 0;
    localparam int SX_N  = 1;
    localparam int SX_F  = 4;
    localparam int SX_T  = 12;

    localparam logic [OP_W-1:0] OP_TRAP  = 14'h000;
    localparam logic [OP_W-1:0] OP_NOT   = 14'h001;
    localparam logic [OP_W-1:0] OP_OR    = 14'h002;
    localparam logic [OP_W-1:0] OP_AND   = 14'h003;
    localparam logic [OP_W-1:0] OP_XOR   = 14'h004;
    localparam logic [OP_W-1:0] OP_SHFTR = 14'h005;
    localparam logic [OP_W-1:0] OP_SHFTL = 14'h006;
    localparam logic [OP_W-1:0] OP_ROTR  = 14'h007;
    localparam logic [OP_W-1:0] OP_ROTL  = 14'h008;
    localparam logic [OP_W-1:0] OP_INC   = 14'h009;
    localparam logic [OP_W-1:0] OP_DEC   = 14'h00A;
    localparam logic [OP_W-1:0] OP_ADD   = 14'h00B;
    localparam logic [OP_W-1:0] OP_ADDC  = 14'h00C;
    localparam logic [OP_W-1:0] OP_SUB   = 14'h00D;
    localparam logic [OP_W-1:0] OP_SUBC  = 14'h00E;
    localparam logic [OP_W-1:0] OP_EQ    = 14'h010;
    localparam logic [OP_W-1:0] OP_GT    = 14'h011;
    localparam logic [OP_W-1:0] OP_LT    = 14'h012;
    localparam logic [OP_W-1:0] OP_GET   = 14'h013;
    localparam logic [OP_W-1:0] OP_LET   = 14'h014;
    localparam logic [OP_W-1:0] OP_NOP   = 14'h015;
    localparam logic [OP_W-1:0] OP_LSTAT = 14'h016;
    localparam logic [OP_W-1:0] OP_XSTAT = 14'h017;
    localparam logic [OP_W-1:0] OP_SWAP  = 14'h030;
    localparam logic [OP_W-1:0] OP_MUL   = 14'h040;
    localparam logic [OP_W-1:0] OP_DIV   = 14'h041;
    localparam logic [OP_W-1:0] OP_JMP   = 14'h100;
    localparam logic [OP_W-1:0] OP_JZ    = 14'h101;
    localparam logic [OP_W-1:0] OP_LD    = 14'h240;
    localparam logic [OP_W-1:0] OP_MRR   = 14'h24B;
    localparam logic [OP_W-1:0] OP_ST    = 14'h250;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_WB,
        CLS_CMP,
        CLS_STAT,
        CLS_NOP,
        CLS_TRAP,
        CLS_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/alu_op_class.sv
// Combinational opcode decoder: op class, which SX bits a compare merges
// from the ALU flags, and whether the op updates the carry flag.
module alu_op_class
    import cpu_pkg::*;
(
    input  logic [13:0] op,
    output logic [2:0]  op_class,
    output logic [12:0] flag_mask,
    output logic        carry_update
);

    always_comb begin
        op_class     = CLS_ILLEGAL;
        flag_mask    = '0;
        carry_update = 1'b0;
        case (op)
            OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL, OP_ROTR,
            OP_ROTL, OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
                op_class = CLS_WB;
            end
            OP_ADDC, OP_SUBC: begin
                op_class     = CLS_WB;
                carry_update = 1'b1;
            end
            OP_EQ: begin
                op_class         = CLS_CMP;
                flag_mask[SX_ZE] = 1'b1;
            end
            OP_GT, OP_LT: begin
                op_class        = CLS_CMP;
                flag_mask[SX_N] = 1'b1;
            end
            OP_GET, OP_LET: begin
                op_class         = CLS_CMP;
                flag_mask[SX_ZE] = 1'b1;
                flag_mask[SX_N]  = 1'b1;
            end
            OP_LSTAT, OP_XSTAT: op_class = CLS_STAT;
            OP_NOP:             op_class = CLS_NOP;
            OP_TRAP:            op_class = CLS_TRAP;
            default:            op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: accepts one instruction, reads operands, drives the
// ALU for one cycle, writes back, and owns the SX status register.
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [13:0] instr_op,
    input  logic [3:0]  instr_rd,
    input  logic [3:0]  instr_ra,
    input  logic [3:0]  instr_rb,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [19:0] rf_rdata_a,
    input  logic [19:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [19:0] rf_wdata,
    output logic [13:0] alu_op,
    output logic [19:0] alu_a,
    output logic [19:0] alu_b,
    output logic        alu_cin,
    input  logic [19:0] alu_result,
    input  logic        alu_carry_out,
    input  logic [12:0] alu_flags,
    output logic [12:0] sx,
    output logic        trap,
    input  logic        trap_clear,
    output logic        illegal
);

    seq_state_t  state, state_next;
    logic [13:0] op_q;
    logic [3:0]  rd_q, ra_q, rb_q;
    logic [19:0] a_q, b_q;
    logic [12:0] sx_q, sx_next;
    logic        ready_q;
    logic        accept;
    logic [13:0] dec_op;
    logic [2:0]  dec_class;
    logic [12:0] dec_mask;
    logic        dec_carry;
    logic [19:0] sx_word;

    assign accept      = instr_valid && ready_q && (state == ST_IDLE);
    assign instr_ready = ready_q && (state == ST_IDLE);
    assign dec_op      = (state == ST_IDLE) ? instr_op : op_q;
    assign sx_word     = {{(WORD_W-FLAG_W){1'b0}}, sx_q};
    assign alu_cin     = sx_q[SX_F];
    assign sx          = sx_q;

    alu_op_class u_op_class (
        .op           (dec_op),
        .op_class     (dec_class),
        .flag_mask    (dec_mask),
        .carry_update (dec_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= 1'b1;
        end
    end

    // Operand addresses are presented on the accept edge so the 1-cycle RF
    // read returns data during READ, where it is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_NOP;
            rd_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            sx_q <= '0;
        end else begin
            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                ra_q <= instr_ra;
                rb_q <= instr_rb;
            end
            if (state == ST_READ) begin
                a_q <= rf_rdata_a;
                b_q <= rf_rdata_b;
            end
            sx_q <= sx_next;
        end
    end

    always_comb begin
        state_next = state;
        sx_next    = sx_q;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_op     = OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        illegal    = 1'b0;
        trap       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    rf_raddr_a = instr_ra;
                    rf_raddr_b = instr_rb;
                    if (dec_class == CLS_TRAP) begin
                        state_next    = ST_TRAP;
                        sx_next[SX_T] = 1'b1;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                rf_raddr_a = ra_q;
                rf_raddr_b = rb_q;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                alu_op     = op_q;
                alu_a      = a_q;
                alu_b      = b_q;
                state_next = ST_WB;
            end
            ST_WB: begin
                state_next = ST_IDLE;
                case (dec_class)
                    CLS_WB: begin
                        rf_we    = 1'b1;
                        rf_waddr = rd_q;
                        rf_wdata = alu_result;
                        if (dec_carry) begin
                            sx_next[SX_F] = alu_carry_out;
                        end
                    end
                    CLS_CMP: sx_next = (sx_q & ~dec_mask) | (alu_flags & dec_mask);
                    CLS_STAT: begin
                        if (op_q == OP_LSTAT) begin
                            rf_we    = 1'b1;
                            rf_waddr = rd_q;
                            rf_wdata = sx_word;
                        end else if (sx_q[SX_T]) begin
                            rf_we    = 1'b1;
                            rf_waddr = rd_q;
                            rf_wdata = sx_word ^ a_q;
                        end
                    end
                    CLS_ILLEGAL: illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_TRAP: begin
                trap = 1'b1;
                if (trap_clear) begin
                    sx_next[SX_T] = 1'b0;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural register file, ALU
// and instruction-level reference model.
module tb_alu_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [13:0] instr_op = OP_NOP;
    logic [3:0]  instr_rd = '0, instr_ra = '0, instr_rb = '0;
    logic [3:0]  rf_raddr_a, rf_raddr_b;
    logic [19:0] rf_rdata_a = '0, rf_rdata_b = '0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [19:0] rf_wdata;
    logic [13:0] alu_op;
    logic [19:0] alu_a, alu_b;
    logic        alu_cin;
    logic [19:0] alu_result = '0;
    logic        alu_carry_out = 1'b0;
    logic [12:0] alu_flags = '0;
    logic [12:0] sx;
    logic        trap;
    logic        trap_clear = 1'b0;
    logic        illegal;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [19:0] data;
    } wr_t;

    wr_t         exp_wr [$];
    int          exp_ill [$];
    logic [12:0] exp_sx [$];

    logic [19:0] rf_mem [16];
    logic [19:0] mregs [16];
    logic [12:0] msx = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_ready = 1'b0;
    wr_t         mon_e;
    int          mon_c;
    logic [13:0] op_list [$];

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out), .alu_flags(alu_flags),
        .sx(sx), .trap(trap), .trap_clear(trap_clear), .illegal(illegal)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU semantics: {carry, flags, result}.
    function automatic logic [33:0] alu_fn(input logic [13:0] op, input logic [19:0] a,
                                           input logic [19:0] b, input logic cin);
        logic [20:0] s;
        logic [19:0] r;
        logic        c, eq, rel;
        s = '0;
        r = '0;
        c = 1'b0;
        case (op)
            OP_NOT:   r = ~a;
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_XOR:   r = a ^ b;
            OP_SHFTR: r = a >> 1;
            OP_SHFTL: r = a << 1;
            OP_ROTR:  r = {a[0], a[19:1]};
            OP_ROTL:  r = {a[18:0], a[19]};
            OP_INC:   r = a + 20'd1;
            OP_DEC:   r = a - 20'd1;
            OP_ADD:   s = {1'b0, a} + {1'b0, b};
            OP_ADDC:  s = {1'b0, a} + {1'b0, b} + {20'b0, cin};
            OP_SUB:   s = {1'b0, a} + {1'b0, ~b} + 21'd1;
            OP_SUBC:  s = {1'b0, a} + {1'b0, ~b} + {20'b0, cin};
            default:  r = '0;
        endcase
        if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC}) begin
            r = s[19:0];
            c = s[20];
        end
        case (op)
            OP_GT:   rel = a > b;
            OP_LT:   rel = a < b;
            OP_GET:  rel = a >= b;
            OP_LET:  rel = a <= b;
            default: rel = r[19];
        endcase
        eq = (op inside {OP_EQ, OP_GT, OP_LT, OP_GET, OP_LET}) ? (a == b) : (r == 20'd0);
        return {c, 11'h5A5, rel, eq, r};
    endfunction

    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        rf_rdata_a <= rf_mem[rf_raddr_a];
        rf_rdata_b <= rf_mem[rf_raddr_b];
    end

    always @(posedge clk) begin
        if (alu_op != OP_NOP)
            {alu_carry_out, alu_flags, alu_result} <= alu_fn(alu_op, alu_a, alu_b, alu_cin);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic preload(input int r, input logic [19:0] v);
        rf_mem[r] = v;
        mregs[r]  = v;
    endtask

    // Instruction-level model: one accepted instruction -> its architectural effect.
    task automatic modelIssue(input logic [13:0] op, input logic [3:0] rd, input logic [3:0] ra,
                              input logic [3:0] rb, input int c0);
        logic [33:0] o;
        logic [19:0] a, wdata;
        logic        do_write;
        a        = mregs[ra];
        o        = alu_fn(op, a, mregs[rb], msx[SX_F]);
        do_write = 1'b0;
        wdata    = '0;
        if (op inside {OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL,
                       OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC}) begin
            do_write = 1'b1;
            wdata    = o[19:0];
            if (op == OP_ADDC || op == OP_SUBC) msx[SX_F] = o[33];
        end else if (op == OP_EQ) begin
            msx[SX_ZE] = o[20];
        end else if (op == OP_GT || op == OP_LT) begin
            msx[SX_N] = o[21];
        end else if (op == OP_GET || op == OP_LET) begin
            msx[1:0] = o[21:20];
        end else if (op == OP_LSTAT) begin
            do_write = 1'b1;
            wdata    = {7'b0, msx};
        end else if (op == OP_XSTAT) begin
            if (msx[SX_T]) begin
                do_write = 1'b1;
                wdata    = {7'b0, msx} ^ a;
            end
        end else if (op != OP_NOP) begin
            exp_ill.push_back(c0 + 2);
        end
        if (do_write) begin
            exp_wr.push_back('{c0 + 2, rd, wdata});
            mregs[rd] = wdata;
        end
        exp_sx.push_back(msx);
    endtask

    task automatic applyStimulus(input logic [13:0] op, input logic [3:0] rd, input logic [3:0] ra,
                                 input logic [3:0] rb, input bit track);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            checkOutput("ready_timeout", {31'b0, instr_ready}, 32'd1);
            return;
        end
        instr_op    = op;
        instr_rd    = rd;
        instr_ra    = ra;
        instr_rb    = rb;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (op == OP_TRAP) msx[SX_T] = 1'b1;
        else if (track) modelIssue(op, rd, ra, rb, cyc);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, {31'b0, instr_ready}, 32'd0);
        checkOutput({tag, "_rf_we"}, {31'b0, rf_we}, 32'd0);
        checkOutput({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
        checkOutput({tag, "_trap"}, {31'b0, trap}, 32'd0);
        checkOutput({tag, "_sx"}, {19'b0, sx}, 32'd0);
        checkOutput({tag, "_alu_op"}, {18'b0, alu_op}, {18'b0, OP_NOP});
        checkOutput({tag, "_alu_a"}, {12'b0, alu_a}, 32'd0);
        checkOutput({tag, "_raddr"}, {24'b0, rf_raddr_a, rf_raddr_b}, 32'd0);
        checkOutput({tag, "_wr"}, {8'b0, rf_waddr, rf_wdata}, 32'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, an
    // illegal pulse, or returns to idle.
    always @(negedge clk) begin
        if (rf_we) begin
            if (exp_wr.size() == 0) begin
                checkOutput("unexpected_write", {31'b0, rf_we}, 32'd0);
            end else begin
                mon_e = exp_wr.pop_front();
                checkOutput("wr_cycle", cyc, mon_e.cyc);
                checkOutput("wr_addr", {28'b0, rf_waddr}, {28'b0, mon_e.addr});
                checkOutput("wr_data", {12'b0, rf_wdata}, {12'b0, mon_e.data});
            end
        end
        if (illegal) begin
            if (exp_ill.size() == 0) begin
                checkOutput("unexpected_illegal", {31'b0, illegal}, 32'd0);
            end else begin
                mon_c = exp_ill.pop_front();
                checkOutput("illegal_cycle", cyc, mon_c);
            end
        end
        if (instr_ready && !prev_ready && exp_sx.size() > 0)
            checkOutput("sx_after_instr", {19'b0, sx}, {19'b0, exp_sx.pop_front()});
        if (instr_ready)
            checkOutput("idle_alu_op", {18'b0, alu_op}, {18'b0, OP_NOP});
        prev_ready <= instr_ready;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) preload(i, '0);
        op_list = '{OP_NOT, OP_OR, OP_AND, OP_XOR, OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL,
                    OP_INC, OP_DEC, OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_EQ, OP_GT, OP_LT,
                    OP_GET, OP_LET, OP_NOP, OP_LSTAT, OP_XSTAT, OP_SWAP, OP_MUL, OP_DIV,
                    OP_JMP, OP_JZ, OP_LD, OP_MRR, OP_ST, 14'h3FF};

        #2 rst_n = 1'b0;
        #1 checkResetOutputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("ready_after_release", {31'b0, instr_ready}, 32'd1);

        preload(1, 20'd5);       preload(2, 20'd7);
        preload(4, 20'hFFFFF);   preload(5, 20'h00001);
        preload(6, 20'd0);       preload(7, 20'd0);
        preload(9, 20'h12345);   preload(10, 20'h12345);
        preload(11, 20'd3);      preload(12, 20'd9);

        applyStimulus(OP_ADD, 4'd3, 4'd1, 4'd2, 1'b1);
        applyStimulus(OP_ADDC, 4'd8, 4'd4, 4'd5, 1'b1);
        applyStimulus(OP_ADDC, 4'd13, 4'd6, 4'd7, 1'b1);
        applyStimulus(OP_EQ, 4'd15, 4'd9, 4'd10, 1'b1);
        applyStimulus(OP_GT, 4'd15, 4'd11, 4'd12, 1'b1);
        repeat (5) @(negedge clk);
        checkOutput("add_result", {12'b0, rf_mem[3]}, 32'h0000C);
        checkOutput("addc_wrap", {12'b0, rf_mem[8]}, 32'h00000);
        checkOutput("addc_cin", {12'b0, rf_mem[13]}, 32'h00001);
        checkOutput("eq_then_gt_sx", {30'b0, sx[1:0]}, 32'd1);

        applyStimulus(OP_TRAP, 4'd0, 4'd0, 4'd0, 1'b1);
        instr_op    = OP_ADD;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("trap_high", {31'b0, trap}, 32'd1);
            checkOutput("trap_ready_low", {31'b0, instr_ready}, 32'd0);
            checkOutput("trap_sx", {19'b0, sx}, {19'b0, msx});
        end
        instr_valid = 1'b0;
        msx[SX_T]   = 1'b0;
        exp_sx.push_back(msx);
        trap_clear  = 1'b1;
        @(posedge clk);
        #1;
        trap_clear = 1'b0;
        checkOutput("trap_released_ready", {31'b0, instr_ready}, 32'd1);
        checkOutput("trap_released_trap", {31'b0, trap}, 32'd0);

        applyStimulus(OP_MRR, 4'd3, 4'd1, 4'd2, 1'b1);
        applyStimulus(OP_SUB, 4'd14, 4'd12, 4'd11, 1'b1);
        applyStimulus(OP_LSTAT, 4'd0, 4'd0, 4'd0, 1'b1);
        repeat (5) @(negedge clk);

        applyStimulus(OP_ADD, 4'd5, 4'd1, 4'd2, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        msx = '0;
        #1 checkResetOutputs("abort");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("ready_at_release", {31'b0, instr_ready}, 32'd0);
        @(posedge clk);
        #1 checkOutput("ready_after_abort", {31'b0, instr_ready}, 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("abort_no_write", {12'b0, rf_mem[5]}, {12'b0, mregs[5]});

        for (int i = 0; i < 16; i++) preload(i, 20'($urandom));
        for (int n = 0; n < 90; n++) begin
            trap_clear = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(op_list[$urandom_range(0, op_list.size() - 1)],
                          4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        end
        trap_clear = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("final_r%0d", i), {12'b0, rf_mem[i]}, {12'b0, mregs[i]});
        checkOutput("pending_writes", exp_wr.size(), 32'd0);
        checkOutput("pending_illegal", exp_ill.size(), 32'd0);
        checkOutput("pending_sx", exp_sx.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
